aud_adc_receiver: RTL and testbench

// - Capture side of the WM8731 codec serial audio link, the opposite direction to the DAC data path.
// - Oversamples codec-mastered BCLK, ADCLRCK and ADCDAT, deserialises one stereo frame (left, then right).
// - Presents each frame on a valid/ready interface to the effect chain and loop recorder.
// - Requires i_clk >= 4x BCLK frequency.

---
 rtl/aud_pkg.sv | 9 +
 rtl/aud_pin_sync.sv | 24 ++
 rtl/aud_adc_receiver.sv | 112 +++++++++++
 tb/tb_aud_adc_receiver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// aud_pkg: shared types and constants for the codec audio capture path.
// Holds the capture FSM state encoding, the default sample width and the
// BIT_DELAY values for the two supported serial formats.
package aud_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_LEFT, S_RIGHT} aud_state_e;
    localparam int AUD_DATA_W    = 16;
    localparam int BIT_DELAY_I2S = 1;
    localparam int BIT_DELAY_LJ  = 0;
endpackage

// File: rtl/aud_pin_sync.sv
// aud_pin_sync: N-stage synchroniser for an asynchronous pin, with rise detect.
// Ports: i_clk/i_rst system clock and sync reset, i_d raw pin,
//        o_rise one-cycle pulse when the synchronised pin goes 0->1.
module aud_pin_sync #(
    parameter int N = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);
    logic [N-1:0] sync_q;
    logic         prev_q;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[N-2:0], i_d};
            prev_q <= sync_q[N-1];
        end
    end
    assign o_rise = sync_q[N-1] & ~prev_q;
endmodule

// File: rtl/aud_adc_receiver.sv
// aud_adc_receiver: deserialises codec ADC stereo frames onto a valid/ready output.
// Ports: i_clk/i_rst clock and sync reset, i_en capture enable,
//        i_bclk/i_lrck/i_adcdat asynchronous codec pins,
//        o_left/o_right/o_valid/i_ready held frame handshake,
//        o_overrun/i_clr_ovr sticky dropped-frame flag, o_busy shifting a channel.
module aud_adc_receiver
    import aud_pkg::*;
#(
    parameter int DATA_W      = AUD_DATA_W,
    parameter int BIT_DELAY   = BIT_DELAY_I2S,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_bclk,
    input  logic              i_lrck,
    input  logic              i_adcdat,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_overrun,
    input  logic              i_clr_ovr,
    output logic              o_busy
);
    localparam int CW = $clog2(DATA_W + BIT_DELAY + 1);
    localparam int IW = $clog2(DATA_W);
    localparam logic [CW-1:0] C_LO  = CW'(BIT_DELAY);
    localparam logic [CW-1:0] C_HI  = CW'(BIT_DELAY + DATA_W);
    localparam logic [IW-1:0] I_TOP = IW'(DATA_W - 1 + BIT_DELAY);

    logic [SYNC_STAGES-1:0] lrck_sq, dat_sq;
    logic                   bit_stb, lrck_s, dat_s, lrck_prev_q, lrck_edge;
    logic                   cap, frame_done, load;
    aud_state_e             state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx;
    logic [DATA_W-1:0]      sh_q, left_w_q, left_q, right_q;
    logic                   valid_q, ovr_q;

    aud_pin_sync #(.N(SYNC_STAGES)) u_bclk_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_d    (i_bclk),
        .o_rise (bit_stb)
    );

    // LRCK and data use the same depth as BCLK so all three stay aligned.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lrck_sq <= '0;
            dat_sq  <= '0;
        end else begin
            lrck_sq <= {lrck_sq[SYNC_STAGES-2:0], i_lrck};
            dat_sq  <= {dat_sq[SYNC_STAGES-2:0], i_adcdat};
        end
    end

    assign lrck_s     = lrck_sq[SYNC_STAGES-1];
    assign dat_s      = dat_sq[SYNC_STAGES-1];
    assign lrck_edge  = bit_stb & (lrck_s ^ lrck_prev_q);
    // cnt_q counts strobes since the slot's LRCK edge (the edge strobe is 0).
    assign cap        = (cnt_q >= C_LO) && (cnt_q < C_HI);
    assign idx        = I_TOP - IW'(cnt_q);
    assign frame_done = i_en && state_q == S_RIGHT && lrck_edge && !lrck_s;
    assign load       = !valid_q || i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            lrck_prev_q <= 1'b0;
            cnt_q       <= '0;
            sh_q        <= '0;
            left_w_q    <= '0;
            left_q      <= '0;
            right_q     <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (bit_stb) lrck_prev_q <= lrck_s;
            if (!i_en) state_q <= S_IDLE;
            else if (state_q == S_IDLE) state_q <= S_ALIGN;
            else if (state_q == S_ALIGN) begin
                if (lrck_edge && !lrck_s) state_q <= S_LEFT;
            end else if (lrck_edge)
                state_q <= (state_q == S_LEFT && lrck_s) ? S_RIGHT :
                           (state_q == S_RIGHT && !lrck_s) ? S_LEFT : S_ALIGN;
            if (state_q == S_LEFT && lrck_edge) left_w_q <= sh_q;
            // A fresh slot starts zeroed so missing LSBs commit as zero.
            if (lrck_edge) begin
                cnt_q <= CW'(1);
                sh_q  <= {(BIT_DELAY == 0) && dat_s, {(DATA_W-1){1'b0}}};
            end else if (bit_stb) begin
                cnt_q <= (cnt_q == C_HI) ? cnt_q : cnt_q + CW'(1);
                if (cap) sh_q[idx] <= dat_s;
            end
            if (frame_done && load) begin
                left_q  <= left_w_q;
                right_q <= sh_q;
                valid_q <= 1'b1;
            end else if (valid_q && i_ready) valid_q <= 1'b0;
            ovr_q <= (frame_done && !load) || (ovr_q && !i_clr_ovr);
        end
    end

    assign o_left    = left_q;
    assign o_right   = right_q;
    assign o_valid   = valid_q;
    assign o_overrun = ovr_q;
    assign o_busy    = (state_q == S_LEFT) || (state_q == S_RIGHT);
endmodule

// File: tb/tb_aud_adc_receiver.sv
// tb_aud_adc_receiver: directed frame vectors and corner sequences for aud_adc_receiver.
module tb_aud_adc_receiver;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0;
    logic        bclk = 1'b0, lrck = 1'b0, dat = 1'b0, ready = 1'b1, clr_ovr = 1'b0;
    logic [15:0] left, right;
    logic        valid, ovr, busy;
    int          n_vec = 0, n_err = 0, n_acc = 0, c0;
    logic [15:0] acc_l = '0, acc_r = '0;

    typedef struct {
        logic [31:0] lb, rb;
        int          nl, nr;
        logic [15:0] el, er;
    } vec_t;
    vec_t tbl[5];

    aud_adc_receiver dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_bclk    (bclk),
        .i_lrck    (lrck),
        .i_adcdat  (dat),
        .o_left    (left),
        .o_right   (right),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_overrun (ovr),
        .i_clr_ovr (clr_ovr),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && valid && ready) begin
            n_acc++;
            acc_l = left;
            acc_r = right;
        end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input logic lr, input logic d);
        @(negedge clk);
        bclk = 1'b0;
        lrck = lr;
        dat  = d;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic bits(input logic lr, input logic [31:0] b, input int n);
        for (int i = 0; i < n; i++) tick(lr, b[31-i]);
    endtask

    task automatic slot(input logic lr, input logic [31:0] b, input int n);
        tick(lr, 1'b0);
        bits(lr, b, n);
    endtask

    initial begin
        tbl[0] = '{32'hA5C3_0000, 32'h1234_0000, 16, 16, 16'hA5C3, 16'h1234};
        tbl[1] = '{32'hFFF0_0000, 32'h8880_0000, 12, 12, 16'hFFF0, 16'h8880};
        tbl[2] = '{32'hABCD_E000, 32'h5A5A_F000, 20, 20, 16'hABCD, 16'h5A5A};
        tbl[3] = '{32'h0001_0000, 32'h8000_0000, 16, 16, 16'h0001, 16'h8000};
        tbl[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32, 1, 16'hFFFF, 16'h0000};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset left", 32'(left), 0);
        chk("reset right", 32'(right), 0);
        chk("reset valid", 32'(valid), 0);
        chk("reset overrun", 32'(ovr), 0);
        chk("reset busy", 32'(busy), 0);

        slot(1'b1, 32'hFFFF_0000, 8);
        slot(1'b0, 32'hAAAA_0000, 8);
        chk("disabled valid", 32'(valid), 0);
        chk("disabled busy", 32'(busy), 0);
        chk("disabled count", 32'(n_acc), 0);

        en = 1'b1;
        slot(1'b1, 32'h0, 3);
        chk("align busy", 32'(busy), 0);

        for (int i = 0; i < 5; i++) begin
            slot(1'b0, tbl[i].lb, tbl[i].nl);
            if (i > 0) begin
                chk("vec count", 32'(n_acc), 32'(i));
                chk("vec left", 32'(acc_l), 32'(tbl[i-1].el));
                chk("vec right", 32'(acc_r), 32'(tbl[i-1].er));
            end
            slot(1'b1, tbl[i].rb, tbl[i].nr);
        end

        @(negedge clk);
        bclk = 1'b0;
        lrck = 1'b0;
        dat  = 1'b0;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        repeat (2) @(negedge clk);
        chk("latency early", 32'(valid), 0);
        @(negedge clk);
        chk("latency valid", 32'(valid), 1);
        chk("last left", 32'(left), 32'(tbl[4].el));
        chk("last right", 32'(right), 32'(tbl[4].er));
        @(negedge clk);
        chk("pulse end", 32'(valid), 0);

        ready = 1'b0;
        bits(1'b0, 32'h1111_0000, 16);
        slot(1'b1, 32'h2222_0000, 16);
        tick(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold valid", 32'(valid), 1);
        chk("hold left", 32'(left), 16'h1111);
        chk("hold right", 32'(right), 16'h2222);
        chk("hold no ovr", 32'(ovr), 0);
        bits(1'b0, 32'h3333_0000, 16);
        slot(1'b1, 32'h4444_0000, 16);
        tick(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("ovr valid", 32'(valid), 1);
        chk("ovr left kept", 32'(left), 16'h1111);
        chk("ovr right kept", 32'(right), 16'h2222);
        chk("ovr set", 32'(ovr), 1);
        clr_ovr = 1'b1;
        ready   = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("ovr cleared", 32'(ovr), 0);
        chk("accept valid", 32'(valid), 0);
        @(negedge clk);
        c0 = n_acc;

        en = 1'b0;
        slot(1'b1, 32'h9999_0000, 16);
        tick(1'b0, 1'b0);
        bits(1'b0, 32'h7777_0000, 8);
        en = 1'b1;
        bits(1'b0, 32'h7700_0000, 8);
        chk("midslot busy", 32'(busy), 0);
        slot(1'b1, 32'h6666_0000, 16);
        chk("midslot count", 32'(n_acc), 32'(c0));
        slot(1'b0, 32'hA1A1_0000, 16);
        slot(1'b1, 32'hB2B2_0000, 16);
        chk("midslot count2", 32'(n_acc), 32'(c0));
        tick(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("midslot frame", 32'(n_acc), 32'(c0 + 1));
        chk("midslot left", 32'(acc_l), 16'hA1A1);
        chk("midslot right", 32'(acc_r), 16'hB2B2);

        c0 = n_acc;
        bits(1'b0, 32'hC3C3_0000, 7);
        chk("drop busy before", 32'(busy), 1);
        en = 1'b0;
        @(negedge clk);
        chk("drop busy after", 32'(busy), 0);
        bits(1'b0, 32'h3C3C_0000, 9);
        slot(1'b1, 32'hD4D4_0000, 8);
        en = 1'b1;
        bits(1'b1, 32'h4D4D_0000, 8);
        chk("drop no valid", 32'(n_acc), 32'(c0));
        slot(1'b0, 32'hE5E5_0000, 16);
        slot(1'b1, 32'hF6F6_0000, 16);
        tick(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("reenable frame", 32'(n_acc), 32'(c0 + 1));
        chk("reenable left", 32'(acc_l), 16'hE5E5);
        chk("reenable right", 32'(acc_r), 16'hF6F6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
